// File: rtl/tdm_demux8.sv
// Receive side of a slot-interleaved serial link: aligns on the slot-0 sync
// marker, collects CHANNELS slots and presents each complete frame in parallel.
module tdm_demux8 #(
    parameter int CHANNELS = 8,
    parameter int W        = 1,
    localparam int SELW    = $clog2(CHANNELS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [W-1:0]          din,
    input  logic                  din_valid,
    input  logic                  sync,
    output logic [CHANNELS*W-1:0] ch_out,
    output logic                  frame_valid,
    output logic [SELW-1:0]       slot,
    output logic                  sync_err,
    output logic                  locked
);

    typedef enum logic {HUNT, LOCK} state_t;

    localparam logic [SELW-1:0] LAST_SLOT = SELW'(CHANNELS - 1);

    state_t                state_q, state_d;
    logic [SELW-1:0]       slot_q, slot_d;
    logic [CHANNELS*W-1:0] buf_q, buf_d;
    logic [CHANNELS*W-1:0] ch_out_q, ch_out_d;
    logic                  frame_valid_q, frame_valid_d;
    logic                  sync_err_q, sync_err_d;

    // din and sync are only meaningful on edges where din_valid=1; there is no
    // backpressure, every valid beat is consumed on the edge that samples it.
    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q;
        buf_d         = buf_q;
        ch_out_d      = ch_out_q;
        frame_valid_d = 1'b0;
        sync_err_d    = 1'b0;
        if (din_valid) begin
            case (state_q)
                HUNT: begin
                    if (sync) begin
                        buf_d[W-1:0] = din;
                        slot_d       = SELW'(1);
                        state_d      = LOCK;
                    end
                end
                LOCK: begin
                    if (sync) begin
                        // A marker anywhere but slot 0 restarts the frame at this beat.
                        sync_err_d   = (slot_q != '0);
                        buf_d[W-1:0] = din;
                        slot_d       = SELW'(1);
                    end else if (slot_q == '0) begin
                        sync_err_d = 1'b1;
                        state_d    = HUNT;
                    end else if (slot_q == LAST_SLOT) begin
                        ch_out_d                         = buf_q;
                        ch_out_d[(CHANNELS-1)*W +: W]    = din;
                        frame_valid_d                    = 1'b1;
                        slot_d                           = '0;
                    end else begin
                        buf_d[int'(slot_q)*W +: W] = din;
                        slot_d                     = slot_q + SELW'(1);
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= HUNT;
            slot_q        <= '0;
            buf_q         <= '0;
            ch_out_q      <= '0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            buf_q         <= buf_d;
            ch_out_q      <= ch_out_d;
            frame_valid_q <= frame_valid_d;
            sync_err_q    <= sync_err_d;
        end
    end

    assign ch_out      = ch_out_q;
    assign frame_valid = frame_valid_q;
    assign slot        = slot_q;
    assign sync_err    = sync_err_q;
    assign locked      = (state_q == LOCK);

endmodule
